sfx_tone_sequencer: RTL
=======================

// Module: sfx_tone_sequencer
// PURPOSE
//  ROM-driven square-wave sound-effect player, generalising the single-effect game-over tone.
//  Plays a caller-selected range of half-period entries [start, end], one note per NOTE_TICKS.
//  Supports one-shot or loop modes, retrigger, abort, rests and attenuation.
//  Adds the tone to a pass-through audio sample (mic/ADC path) with saturation, ahead of Audio_Controller.
// PARAMETERS
//  ADDR_W     16        note ROM address width
//  HP_W       19        half-period width (CLOCK_50 cycles per tone phase, minus 1)
//  SAMPLE_W   32        signed audio sample width
//  AMPLITUDE  10000000  tone peak magnitude at attenuation 0; must be < 2^(SAMPLE_W-1)
//  NOTE_TICKS 400000    CLOCK_50 cycles per note step, >= 4
//  ROM_LAT    2         cycles from rom_addr change to valid rom_q (synchronous ROM)
// PORTS
//  CLOCK_50   in   1         system clock, all logic on rising edge
//  reset      in   1         asynchronous, active-high
//  trigger    in   1         1-cycle start/restart strobe
//  stop       in   1         abort playback
//  start_addr in   ADDR_W    first note address, sampled on trigger
//  end_addr   in   ADDR_W    last note address, sampled on trigger
//  loop_en    in   1         1 = wrap to start after end, sampled on trigger
//  atten      in   3         tone = AMPLITUDE >>> atten, sampled on trigger
//  rom_addr   out  ADDR_W    note ROM address
//  rom_q      in   HP_W      half-period from ROM; 0 = rest
//  mix_in     in   SAMPLE_W  signed pass-through sample
//  mix_out    out  SAMPLE_W  signed sat(mix_in + tone), registered
//  busy       out  1         high in FETCH or PLAY
//  done       out  1         1-cycle pulse on natural completion
// BEHAVIOUR
//  Reset (async): state IDLE; rom_addr, mix_out, busy, done, all counters, phase and hp_reg = 0.
//  States: IDLE, FETCH, PLAY, DONE.
//  IDLE: tone = 0. On trigger: capture start/end/loop/atten, rom_addr <= start_addr, go to FETCH.
//  FETCH: wait ROM_LAT cycles after the rom_addr update. Then hp_reg <= rom_q, note_cnt <= 0,
//   tone_cnt <= 0, phase <= 1, go to PLAY. The tone keeps running on the old hp_reg during FETCH
//   (no click); on the first FETCH after IDLE, hp_reg = 0, so the output is silent.
//  PLAY: tone_cnt increments each cycle. When tone_cnt == hp_reg: tone_cnt <= 0, phase toggles.
//   Tone period is therefore 2*(hp_reg+1) cycles. hp_reg == 0 gives a rest: tone = 0, phase held.
//   tone = phase ? +(AMPLITUDE>>>atten) : -(AMPLITUDE>>>atten), sign-extended to SAMPLE_W.
//   note_cnt == NOTE_TICKS-1 ends the note:
//    - rom_addr != end: rom_addr <= rom_addr+1 (mod 2^ADDR_W, so end < start wraps through 0), go to FETCH.
//    - rom_addr == end and loop_en: rom_addr <= start, go to FETCH.
//    - rom_addr == end and !loop_en: go to DONE.
//  DONE: done = 1 for exactly one cycle, tone = 0, then IDLE. busy = 0 in DONE and IDLE.
//  Note timing: FETCH+PLAY per note = ROM_LAT + NOTE_TICKS cycles.
//  Priority (same cycle): reset > stop > trigger > sequencing.
//  stop in any state: go to IDLE next cycle, tone = 0, no done pulse.
//  trigger while busy or in DONE: restart from the new start_addr via FETCH, no done for the old effect.
//  stop and trigger together: stop wins; the trigger is ignored.
//  mix_out <= sat(mix_in + tone), computed at SAMPLE_W+1 bits and clamped to
//   [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1]. Latency is 1 cycle; mix_out passes mix_in when idle.
// TESTING  (bench params: NOTE_TICKS=20, ROM_LAT=2, AMPLITUDE=1000, SAMPLE_W=16; ROM[a] = a%4)
//  1. trigger, start=1, end=3, loop=0, mix_in=0 -> rom_addr 1,2,3. mix_out toggles ±1000 with periods 4,6,8.
//     done pulses once after 3*(2+20)+1 cycles; busy falls with done.
//  2. start=4 (ROM=0, rest), end=4 -> mix_out stays 0 for the whole note, then done pulses.
//  3. loop=1, start=2, end=3 -> address sequence 2,3,2,3,...; done never pulses.
//     stop -> IDLE next cycle, mix_out = mix_in, no done.
//  4. start=0xFFFF, end=1 -> addresses FFFF,0,1, then done (wrap-around).
//  5. mix_in=32000, atten=0, phase high -> mix_out = 32767.
//     mix_in=-32500, phase low -> mix_out = -32768. atten=2 -> magnitude 250.
//  6. Retrigger mid-note with start=3 -> FETCH at addr 3, no done for the aborted effect.
//     reset asserted mid-PLAY -> all outputs 0 immediately (async).

Source files
------------

// File: rtl/sfx_tone_sequencer.sv
// rtl/sfx_tone_sequencer.sv - ROM-driven square-wave sound-effect sequencer with saturating mix
module sfx_tone_sequencer #(
    parameter int ADDR_W     = 16,
    parameter int HP_W       = 19,
    parameter int SAMPLE_W   = 32,
    parameter int AMPLITUDE  = 10000000,
    parameter int NOTE_TICKS = 400000,
    parameter int ROM_LAT    = 2
) (
    input  logic                       CLOCK_50,
    input  logic                       reset,
    input  logic                       trigger,
    input  logic                       stop,
    input  logic [ADDR_W-1:0]          start_addr,
    input  logic [ADDR_W-1:0]          end_addr,
    input  logic                       loop_en,
    input  logic [2:0]                 atten,
    output logic [ADDR_W-1:0]          rom_addr,
    input  logic [HP_W-1:0]            rom_q,
    input  logic signed [SAMPLE_W-1:0] mix_in,
    output logic signed [SAMPLE_W-1:0] mix_out,
    output logic                       busy,
    output logic                       done
);

    localparam int NOTE_W = (NOTE_TICKS > 1) ? $clog2(NOTE_TICKS) : 1;
    localparam int LAT_W  = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
    localparam logic [NOTE_W-1:0] NOTE_LAST = NOTE_W'(NOTE_TICKS - 1);
    localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(ROM_LAT - 1);
    localparam logic signed [SAMPLE_W-1:0] AMP     = SAMPLE_W'(AMPLITUDE);
    localparam logic signed [SAMPLE_W-1:0] SAT_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [SAMPLE_W-1:0] SAT_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_PLAY  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               state_q;
    logic [ADDR_W-1:0]    rom_addr_q;
    logic [ADDR_W-1:0]    start_q;
    logic [ADDR_W-1:0]    end_q;
    logic                 loop_q;
    logic [2:0]           atten_q;
    logic [LAT_W-1:0]     fetch_cnt_q;
    logic [NOTE_W-1:0]    note_cnt_q;
    logic [HP_W-1:0]      tone_cnt_q;
    logic [HP_W-1:0]      hp_q;
    logic                 phase_q;
    logic                 busy_q;
    logic                 done_q;
    logic signed [SAMPLE_W-1:0] mix_out_q;

    logic                       sounding_d;
    logic signed [SAMPLE_W-1:0] amp_d;
    logic signed [SAMPLE_W-1:0] tone_d;
    logic signed [SAMPLE_W:0]   sum_d;
    logic signed [SAMPLE_W-1:0] mix_out_d;

    assign rom_addr = rom_addr_q;
    assign mix_out  = mix_out_q;
    assign busy     = busy_q;
    assign done     = done_q;

    // The square wave keeps running through FETCH so note changes do not click.
    assign sounding_d = (state_q == S_FETCH) || (state_q == S_PLAY);
    assign amp_d      = AMP >>> atten_q;

    always_comb begin
        tone_d = '0;
        if (sounding_d && (hp_q != '0)) begin
            tone_d = phase_q ? amp_d : -amp_d;
        end
    end

    always_comb begin
        sum_d     = {mix_in[SAMPLE_W-1], mix_in} + {tone_d[SAMPLE_W-1], tone_d};
        mix_out_d = sum_d[SAMPLE_W-1:0];
        if (sum_d[SAMPLE_W] != sum_d[SAMPLE_W-1]) begin
            mix_out_d = sum_d[SAMPLE_W] ? SAT_MIN : SAT_MAX;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            mix_out_q <= '0;
        end else begin
            mix_out_q <= mix_out_d;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rom_addr_q  <= '0;
            start_q     <= '0;
            end_q       <= '0;
            loop_q      <= 1'b0;
            atten_q     <= '0;
            fetch_cnt_q <= '0;
            note_cnt_q  <= '0;
            tone_cnt_q  <= '0;
            hp_q        <= '0;
            phase_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;

            // A rest (hp == 0) freezes the phase generator.
            if (sounding_d && (hp_q != '0)) begin
                if (tone_cnt_q == hp_q) begin
                    tone_cnt_q <= '0;
                    phase_q    <= ~phase_q;
                end else begin
                    tone_cnt_q <= tone_cnt_q + 1'b1;
                end
            end

            if (stop) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
            end else if (trigger) begin
                if ((state_q == S_IDLE) || (state_q == S_DONE)) begin
                    hp_q <= '0;
                end
                start_q     <= start_addr;
                end_q       <= end_addr;
                loop_q      <= loop_en;
                atten_q     <= atten;
                rom_addr_q  <= start_addr;
                fetch_cnt_q <= '0;
                state_q     <= S_FETCH;
                busy_q      <= 1'b1;
            end else begin
                case (state_q)
                    S_FETCH: begin
                        if (fetch_cnt_q == LAT_LAST) begin
                            hp_q       <= rom_q;
                            note_cnt_q <= '0;
                            tone_cnt_q <= '0;
                            phase_q    <= 1'b1;
                            state_q    <= S_PLAY;
                        end else begin
                            fetch_cnt_q <= fetch_cnt_q + 1'b1;
                        end
                    end
                    S_PLAY: begin
                        if (note_cnt_q == NOTE_LAST) begin
                            if (rom_addr_q != end_q) begin
                                rom_addr_q  <= rom_addr_q + 1'b1;
                                fetch_cnt_q <= '0;
                                state_q     <= S_FETCH;
                            end else if (loop_q) begin
                                rom_addr_q  <= start_q;
                                fetch_cnt_q <= '0;
                                state_q     <= S_FETCH;
                            end else begin
                                state_q <= S_DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            note_cnt_q <= note_cnt_q + 1'b1;
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
